// File: rtl/fetch_ifid_pkg.sv
// rtl/fetch_ifid_pkg.sv - shared types and constants for the fetch stage
package fetch_ifid_pkg;

   // 16-bit machine word used for PCs and instructions
   typedef logic [15:0] word_t;

   // Fetch FSM: RUN fetches, HALT parks until a redirect
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   // Major opcode (bits 15:11) that stops fetching
   localparam logic [4:0] OP_HALT = 5'b00000;

   // Default bubble word injected into IF/ID
   localparam word_t NOP_INSTR_DEFAULT = 16'h0800;

   // PC step for 16-bit instructions
   localparam word_t PC_STEP = 16'd2;

   // True when an instruction word carries the HALT opcode
   function automatic logic is_halt(input word_t instr);
      return instr[15:11] == OP_HALT;
   endfunction

endpackage

// File: rtl/fetch_ifid_ifid_reg.sv
// rtl/fetch_ifid_ifid_reg.sv - IF/ID pipeline register with enable and squash
module ifid_reg
   import fetch_ifid_pkg::*;
#(
   parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  squash,
   input  word_t instr_i,
   input  word_t pc_plus2_i,
   input  logic  valid_i,
   output word_t instr_o,
   output word_t pc_plus2_o,
   output logic  valid_o
);

   word_t instr_q;
   word_t pc_plus2_q;
   logic  valid_q;

   // Squash wins over a disabled enable so a redirect can clear a stalled stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
      end else if (squash) begin
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
      end else if (en) begin
         instr_q    <= instr_i;
         pc_plus2_q <= pc_plus2_i;
         valid_q    <= valid_i;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus2_o = pc_plus2_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_ifid.sv
// rtl/fetch_ifid.sv - instruction fetch stage: PC, RUN/HALT FSM and IF/ID register
module fetch_ifid
   import fetch_ifid_pkg::*;
#(
   parameter word_t RESET_PC  = 16'h0000,
   parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_ready,
   output logic [15:0] instr_out,
   output logic [15:0] pc_plus2_out,
   output logic        valid_out,
   output logic        halted,
   output logic        err
);

   word_t        pc_q, pc_d;
   fetch_state_t state_q, state_d;
   logic         err_q, err_d;
   word_t        pc_plus2;
   logic         ifid_en;
   logic         ifid_squash;

   assign pc_plus2 = pc_q + PC_STEP;

   // PC, FSM and sticky error state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Next-PC priority mux: flush > stall > HALT > not ready > normal fetch
   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      err_d       = err_q;
      ifid_en     = 1'b0;
      ifid_squash = 1'b0;
      if (flush) begin
         // Redirects are forced to halfword alignment; an odd target is flagged
         pc_d        = {redirect_pc[15:1], 1'b0};
         state_d     = RUN;
         ifid_squash = 1'b1;
         if (redirect_pc[0]) begin
            err_d = 1'b1;
         end
      end else if (stall) begin
         pc_d = pc_q;
      end else if (state_q == HALT) begin
         ifid_squash = 1'b1;
      end else if (!imem_ready) begin
         ifid_squash = 1'b1;
      end else begin
         // The HALT word itself is delivered to decode as a valid instruction
         pc_d    = pc_plus2;
         ifid_en = 1'b1;
         if (is_halt(imem_data)) begin
            state_d = HALT;
         end
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .en         (ifid_en),
      .squash     (ifid_squash),
      .instr_i    (imem_data),
      .pc_plus2_i (pc_plus2),
      .valid_i    (1'b1),
      .instr_o    (instr_out),
      .pc_plus2_o (pc_plus2_out),
      .valid_o    (valid_out)
   );

   assign imem_addr = pc_q;
   assign halted    = (state_q == HALT);
   assign err       = err_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// tb/tb_fetch_ifid.sv - directed table-driven bench for fetch_ifid
module tb_fetch_ifid;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_ready;
   logic [15:0] instr_out;
   logic [15:0] pc_plus2_out;
   logic        valid_out;
   logic        halted;
   logic        err;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [15:0] NOP = 16'h0800;

   typedef struct {
      string       name;
      logic        stall;
      logic        flush;
      logic [15:0] redir;
      logic        ready;
      logic [15:0] data;
      logic [15:0] e_instr;
      logic [15:0] e_pc2;
      logic        e_valid;
      logic        e_halted;
      logic        e_err;
      logic [15:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   fetch_ifid dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .redirect_pc  (redirect_pc),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .imem_ready   (imem_ready),
      .instr_out    (instr_out),
      .pc_plus2_out (pc_plus2_out),
      .valid_out    (valid_out),
      .halted       (halted),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [15:0] e_instr, input logic [15:0] e_pc2,
                          input logic e_valid, input logic e_halted, input logic e_err,
                          input logic [15:0] e_addr);
      chk({name, ".instr"},  instr_out,           e_instr);
      chk({name, ".pc2"},    pc_plus2_out,        e_pc2);
      chk({name, ".valid"},  {15'd0, valid_out},  {15'd0, e_valid});
      chk({name, ".halted"}, {15'd0, halted},     {15'd0, e_halted});
      chk({name, ".err"},    {15'd0, err},        {15'd0, e_err});
      chk({name, ".addr"},   imem_addr,           e_addr);
   endtask

   task automatic add(input string name, input logic s, input logic f, input logic [15:0] r,
                      input logic rdy, input logic [15:0] d, input logic [15:0] ei,
                      input logic [15:0] ep, input logic ev, input logic eh, input logic ee,
                      input logic [15:0] ea);
      vec_t v;
      v.name = name; v.stall = s; v.flush = f; v.redir = r; v.ready = rdy; v.data = d;
      v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev; v.e_halted = eh; v.e_err = ee; v.e_addr = ea;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic s, input logic f, input logic [15:0] r,
                        input logic rdy, input logic [15:0] d);
      stall = s; flush = f; redirect_pc = r; imem_ready = rdy; imem_data = d;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hC001);

      //   name        stall flush redir     rdy  data      instr     pc2       v     h     e     addr
      add("fetch0",    1'b0, 1'b0, 16'h0000, 1'b1, 16'hC001, 16'hC001, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);
      add("fetch1",    1'b0, 1'b0, 16'h0000, 1'b1, 16'hC102, 16'hC102, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004);
      add("fetch2",    1'b0, 1'b0, 16'h0000, 1'b1, 16'hC203, 16'hC203, 16'h0006, 1'b1, 1'b0, 1'b0, 16'h0006);
      add("fl_0e",     1'b0, 1'b1, 16'h000E, 1'b1, 16'hC203, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h000E);
      add("fetch_0e",  1'b0, 1'b0, 16'h0000, 1'b1, 16'hC300, 16'hC300, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0010);
      add("stall0",    1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'hC300, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0010);
      add("stall1",    1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'hC300, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0010);
      add("fl_stall",  1'b1, 1'b1, 16'h0040, 1'b1, 16'h5555, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040);
      add("fl_20",     1'b0, 1'b1, 16'h0020, 1'b1, 16'h5555, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020);
      add("halt_f",    1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0022, 1'b1, 1'b1, 1'b0, 16'h0022);
      add("halt_b0",   1'b0, 1'b0, 16'h0000, 1'b1, 16'hC400, NOP,      16'h0000, 1'b0, 1'b1, 1'b0, 16'h0022);
      add("halt_b1",   1'b0, 1'b0, 16'h0000, 1'b1, 16'hC400, NOP,      16'h0000, 1'b0, 1'b1, 1'b0, 16'h0022);
      add("halt_st",   1'b1, 1'b0, 16'h0000, 1'b1, 16'hC400, NOP,      16'h0000, 1'b0, 1'b1, 1'b0, 16'h0022);
      add("fl_100",    1'b0, 1'b1, 16'h0100, 1'b1, 16'hC400, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100);
      add("halt_07ff", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h07FF, 16'h07FF, 16'h0102, 1'b1, 1'b1, 1'b0, 16'h0102);
      add("fl_08",     1'b0, 1'b1, 16'h0008, 1'b1, 16'hC400, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008);
      add("nrdy0",     1'b0, 1'b0, 16'h0000, 1'b0, 16'hC500, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008);
      add("nrdy1",     1'b0, 1'b0, 16'h0000, 1'b0, 16'hC500, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008);
      add("nrdy2",     1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008);
      add("rdy_back",  1'b0, 1'b0, 16'h0000, 1'b1, 16'hC505, 16'hC505, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h000A);
      add("fl_33",     1'b0, 1'b1, 16'h0033, 1'b1, 16'hC505, NOP,      16'h0000, 1'b0, 1'b0, 1'b1, 16'h0032);
      add("err_f",     1'b0, 1'b0, 16'h0000, 1'b1, 16'hC606, 16'hC606, 16'h0034, 1'b1, 1'b0, 1'b1, 16'h0034);
      add("err_fl",    1'b0, 1'b1, 16'h0050, 1'b1, 16'hC606, NOP,      16'h0000, 1'b0, 1'b0, 1'b1, 16'h0050);
      add("fl_fffe",   1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hC606, NOP,      16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFE);
      add("wrap",      1'b0, 1'b0, 16'h0000, 1'b1, 16'hC707, 16'hC707, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000);
      add("fl_30",     1'b0, 1'b1, 16'h0030, 1'b1, 16'hC707, NOP,      16'h0000, 1'b0, 1'b0, 1'b1, 16'h0030);
      add("halt_30",   1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0032, 1'b1, 1'b1, 1'b1, 16'h0032);

      // Reset values while rst is held
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all("reset", NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].ready, vecs[i].data);
         @(posedge clk);
         #1;
         chk_all(vecs[i].name, vecs[i].e_instr, vecs[i].e_pc2, vecs[i].e_valid,
                 vecs[i].e_halted, vecs[i].e_err, vecs[i].e_addr);
      end

      // Asynchronous reset mid-HALT with err set, asserted away from any edge
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hC808);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all("async_rst", NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hC808);
      @(posedge clk);
      #1;
      chk_all("post_rst", 16'hC808, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);

      // Reset mid-stall: first fetch after release reads RESET_PC again
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hC909);
      @(posedge clk);
      #1;
      chk_all("stall_hold", 16'hC808, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hCA0A);
      @(posedge clk);
      #1;
      chk_all("rst_stall", 16'hCA0A, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
